// File: rtl/stb_host_adapter_pkg.sv
// Shared types and widths for the StreamTraceBuffer host adapter.
// Holds the command opcode enum, the adapter FSM state enum, the buffer
// interface widths and a helper that widens a status word to a response word.
package stb_host_adapter_pkg;

  localparam int TRB_WIDTH        = 32;
  localparam int TRB_CONTROL_BITS = 4;
  localparam int TRB_STATUS_BITS  = 8;

  typedef enum logic [1:0] {
    OP_CTRL_WR = 2'd0,
    OP_STAT_RD = 2'd1,
    OP_DATA_WR = 2'd2,
    OP_DATA_RD = 2'd3
  } stb_host_op_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CTRL_WR = 3'd1,
    ST_STAT_RD = 3'd2,
    ST_DATA_WR = 3'd3,
    ST_DATA_RD = 3'd4,
    ST_RSP     = 3'd5
  } stb_host_state_e;

  // Zero-extend a buffer status word into a response data word.
  function automatic logic [TRB_WIDTH-1:0] stb_status_to_word(
    input logic [TRB_STATUS_BITS-1:0] status
  );
    logic [TRB_WIDTH-1:0] word;
    word = '0;
    word[TRB_STATUS_BITS-1:0] = status;
    return word;
  endfunction

endpackage

// File: rtl/stb_rsp_slot.sv
// Single-entry ready/valid response register.
// The adapter only loads it when it is empty (or draining in the same cycle),
// so a load always wins over the drain.
module stb_rsp_slot #(
  parameter int WIDTH = 32
) (
  input  logic             CLK_I,
  input  logic             RST_NI,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_last,
  input  logic             load_err,
  input  logic             rsp_ready,
  output logic             rsp_valid,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_last,
  output logic             rsp_err
);

  logic             valid_reg;
  logic [WIDTH-1:0] data_reg;
  logic             last_reg;
  logic             err_reg;

  // Capture a beat on load, release it on the consumer handshake.
  always_ff @(posedge CLK_I) begin
    if (!RST_NI) begin
      valid_reg <= 1'b0;
      data_reg  <= '0;
      last_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else if (load) begin
      valid_reg <= 1'b1;
      data_reg  <= load_data;
      last_reg  <= load_last;
      err_reg   <= load_err;
    end else if (valid_reg && rsp_ready) begin
      valid_reg <= 1'b0;
    end
  end

  assign rsp_valid = valid_reg;
  assign rsp_data  = data_reg;
  assign rsp_last  = last_reg;
  assign rsp_err   = err_reg;

endmodule

// File: rtl/stb_host_adapter.sv
// Host-side initiator for the StreamTraceBuffer CONTROL/STATUS/DATA ports.
// Executes one transport command at a time and returns its result on a
// single response stream. Every output comes straight from a register.
// Optional abort on a stalled buffer: define STB_HOST_TIMEOUT_EN.
module stb_host_adapter
  import stb_host_adapter_pkg::*;
#(
  parameter int LEN_WIDTH   = 8,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                        CLK_I,
  input  logic                        RST_NI,
  input  logic                        CMD_VALID_I,
  output logic                        CMD_READY_O,
  input  logic [1:0]                  CMD_OP_I,
  input  logic [LEN_WIDTH-1:0]        CMD_LEN_I,
  input  logic [TRB_WIDTH-1:0]        CMD_DATA_I,
  output logic                        RSP_VALID_O,
  input  logic                        RSP_READY_I,
  output logic [TRB_WIDTH-1:0]        RSP_DATA_O,
  output logic                        RSP_LAST_O,
  output logic                        RSP_ERR_O,
  output logic                        CONTROL_VALID_O,
  input  logic                        CONTROL_READY_I,
  output logic [TRB_CONTROL_BITS-1:0] CONTROL_O,
  output logic                        STATUS_READY_O,
  input  logic                        STATUS_VALID_I,
  input  logic [TRB_STATUS_BITS-1:0]  STATUS_I,
  output logic                        DATA_VALID_O,
  input  logic                        DATA_READY_I,
  output logic [TRB_WIDTH-1:0]        DATA_O,
  output logic                        DATA_READY_O,
  input  logic                        DATA_VALID_I,
  input  logic [TRB_WIDTH-1:0]        DATA_I
);

  if (TRB_STATUS_BITS > TRB_WIDTH) begin : g_chk_status
    $error("status word wider than response data");
  end
  if (LEN_WIDTH > TRB_WIDTH) begin : g_chk_len
    $error("burst length wider than response data");
  end
  if (TIMEOUT_CYC < 2) begin : g_chk_tmo
    $error("TIMEOUT_CYC must be at least 2");
  end

  stb_host_state_e             state_reg, state_next;
  logic                        cmd_ready_reg, cmd_ready_next;
  logic                        control_valid_reg, control_valid_next;
  logic [TRB_CONTROL_BITS-1:0] control_reg, control_next;
  logic                        status_ready_reg, status_ready_next;
  logic                        data_valid_reg, data_valid_next;
  logic [TRB_WIDTH-1:0]        data_out_reg, data_out_next;
  logic                        data_ready_reg, data_ready_next;
  logic [LEN_WIDTH-1:0]        len_reg, len_next;
  logic [LEN_WIDTH-1:0]        count_reg, count_next;

  logic                        slot_load;
  logic [TRB_WIDTH-1:0]        slot_data;
  logic                        slot_last;
  logic                        slot_err;
  logic                        rsp_valid;
  logic                        buf_hs;
  logic                        timeout_hit;
  logic [TRB_WIDTH-1:0]        abort_data;

  // Any buffer-side handshake counts as progress.
  assign buf_hs = (control_valid_reg && CONTROL_READY_I) ||
                  (status_ready_reg  && STATUS_VALID_I)  ||
                  (data_valid_reg    && DATA_READY_I)    ||
                  (data_ready_reg    && DATA_VALID_I);

`ifdef STB_HOST_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

  logic [TMO_W-1:0] tmo_cnt_reg;
  logic             tmo_busy;

  assign tmo_busy = (state_reg == ST_CTRL_WR) || (state_reg == ST_STAT_RD) ||
                    (state_reg == ST_DATA_WR) || (state_reg == ST_DATA_RD);

  // Idle-cycle counter; saturates so an abort blocked by a full slot still fires later.
  always_ff @(posedge CLK_I) begin
    if (!RST_NI || !tmo_busy || buf_hs) begin
      tmo_cnt_reg <= '0;
    end else if (tmo_cnt_reg != TMO_W'(TIMEOUT_CYC)) begin
      tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
    end
  end

  assign timeout_hit = (tmo_cnt_reg == TMO_W'(TIMEOUT_CYC));

  // Words moved so far, reported as the payload of an aborted command.
  always_comb begin
    abort_data = '0;
    abort_data[LEN_WIDTH-1:0] = count_reg;
  end
`else
  assign timeout_hit = 1'b0;
  assign abort_data  = '0;
`endif

  // Next-state and next-output logic for the command sequencer.
  always_comb begin
    state_next         = state_reg;
    cmd_ready_next     = cmd_ready_reg;
    control_valid_next = control_valid_reg;
    control_next       = control_reg;
    status_ready_next  = status_ready_reg;
    data_valid_next    = data_valid_reg;
    data_out_next      = data_out_reg;
    data_ready_next    = data_ready_reg;
    len_next           = len_reg;
    count_next         = count_reg;
    slot_load          = 1'b0;
    slot_data          = '0;
    slot_last          = 1'b0;
    slot_err           = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (CMD_VALID_I && cmd_ready_reg) begin
          cmd_ready_next = 1'b0;
          case (stb_host_op_e'(CMD_OP_I))
            OP_CTRL_WR: begin
              control_valid_next = 1'b1;
              control_next       = CMD_DATA_I[TRB_CONTROL_BITS-1:0];
              state_next         = ST_CTRL_WR;
            end
            OP_STAT_RD: begin
              status_ready_next = 1'b1;
              state_next        = ST_STAT_RD;
            end
            OP_DATA_WR: begin
              data_valid_next = 1'b1;
              data_out_next   = CMD_DATA_I;
              state_next      = ST_DATA_WR;
            end
            default: begin
              len_next   = CMD_LEN_I;
              count_next = '0;
              if (CMD_LEN_I == '0) begin
                // Empty burst: answer at once without touching the buffer.
                slot_load  = 1'b1;
                slot_last  = 1'b1;
                state_next = ST_RSP;
              end else begin
                data_ready_next = 1'b1;
                state_next      = ST_DATA_RD;
              end
            end
          endcase
        end
      end

      ST_CTRL_WR: begin
        if (CONTROL_READY_I) begin
          control_valid_next = 1'b0;
          slot_load          = 1'b1;
          slot_last          = 1'b1;
          state_next         = ST_RSP;
        end else if (timeout_hit) begin
          control_valid_next = 1'b0;
          slot_load          = 1'b1;
          slot_last          = 1'b1;
          slot_err           = 1'b1;
          slot_data          = abort_data;
          state_next         = ST_RSP;
        end
      end

      ST_STAT_RD: begin
        if (STATUS_VALID_I) begin
          status_ready_next = 1'b0;
          slot_load         = 1'b1;
          slot_data         = stb_status_to_word(STATUS_I);
          slot_last         = 1'b1;
          state_next        = ST_RSP;
        end else if (timeout_hit) begin
          status_ready_next = 1'b0;
          slot_load         = 1'b1;
          slot_last         = 1'b1;
          slot_err          = 1'b1;
          slot_data         = abort_data;
          state_next        = ST_RSP;
        end
      end

      ST_DATA_WR: begin
        if (DATA_READY_I) begin
          data_valid_next = 1'b0;
          slot_load       = 1'b1;
          slot_data       = TRB_WIDTH'(1);
          slot_last       = 1'b1;
          state_next      = ST_RSP;
        end else if (timeout_hit) begin
          data_valid_next = 1'b0;
          slot_load       = 1'b1;
          slot_last       = 1'b1;
          slot_err        = 1'b1;
          slot_data       = abort_data;
          state_next      = ST_RSP;
        end
      end

      ST_DATA_RD: begin
        if (data_ready_reg && DATA_VALID_I) begin
          // Slot was empty (ready only asserts then), so the word lands directly.
          slot_load       = 1'b1;
          slot_data       = DATA_I;
          count_next      = count_reg + 1'b1;
          data_ready_next = 1'b0;
          if (count_next == len_reg) begin
            slot_last  = 1'b1;
            state_next = ST_RSP;
          end
        end else if (timeout_hit && !rsp_valid) begin
          data_ready_next = 1'b0;
          slot_load       = 1'b1;
          slot_last       = 1'b1;
          slot_err        = 1'b1;
          slot_data       = abort_data;
          state_next      = ST_RSP;
        end else begin
          // Offer another word only once the slot is (or is becoming) empty.
          data_ready_next = !rsp_valid || RSP_READY_I;
        end
      end

      ST_RSP: begin
        if (rsp_valid && RSP_READY_I) begin
          cmd_ready_next = 1'b1;
          state_next     = ST_IDLE;
        end
      end

      default: begin
        cmd_ready_next = 1'b1;
        state_next     = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any command in flight.
  always_ff @(posedge CLK_I) begin
    if (!RST_NI) begin
      state_reg         <= ST_IDLE;
      cmd_ready_reg     <= 1'b1;
      control_valid_reg <= 1'b0;
      control_reg       <= '0;
      status_ready_reg  <= 1'b0;
      data_valid_reg    <= 1'b0;
      data_out_reg      <= '0;
      data_ready_reg    <= 1'b0;
      len_reg           <= '0;
      count_reg         <= '0;
    end else begin
      state_reg         <= state_next;
      cmd_ready_reg     <= cmd_ready_next;
      control_valid_reg <= control_valid_next;
      control_reg       <= control_next;
      status_ready_reg  <= status_ready_next;
      data_valid_reg    <= data_valid_next;
      data_out_reg      <= data_out_next;
      data_ready_reg    <= data_ready_next;
      len_reg           <= len_next;
      count_reg         <= count_next;
    end
  end

  stb_rsp_slot #(
    .WIDTH(TRB_WIDTH)
  ) u_rsp_slot (
    .CLK_I     (CLK_I),
    .RST_NI    (RST_NI),
    .load      (slot_load),
    .load_data (slot_data),
    .load_last (slot_last),
    .load_err  (slot_err),
    .rsp_ready (RSP_READY_I),
    .rsp_valid (rsp_valid),
    .rsp_data  (RSP_DATA_O),
    .rsp_last  (RSP_LAST_O),
    .rsp_err   (RSP_ERR_O)
  );

  assign RSP_VALID_O     = rsp_valid;
  assign CMD_READY_O     = cmd_ready_reg;
  assign CONTROL_VALID_O = control_valid_reg;
  assign CONTROL_O       = control_reg;
  assign STATUS_READY_O  = status_ready_reg;
  assign DATA_VALID_O    = data_valid_reg;
  assign DATA_O          = data_out_reg;
  assign DATA_READY_O    = data_ready_reg;

endmodule

// File: tb/tb_stb_host_adapter.sv
// Directed bench for stb_host_adapter with hand-computed expectations.
// The timeout scenario runs only when STB_HOST_TIMEOUT_EN is defined.
module tb_stb_host_adapter;
  import stb_host_adapter_pkg::*;

  localparam int LW = 8;

  logic                        CLK_I = 1'b0;
  logic                        RST_NI = 1'b0;
  logic                        CMD_VALID_I = 1'b0;
  logic                        CMD_READY_O;
  logic [1:0]                  CMD_OP_I = '0;
  logic [LW-1:0]               CMD_LEN_I = '0;
  logic [TRB_WIDTH-1:0]        CMD_DATA_I = '0;
  logic                        RSP_VALID_O;
  logic                        RSP_READY_I = 1'b0;
  logic [TRB_WIDTH-1:0]        RSP_DATA_O;
  logic                        RSP_LAST_O;
  logic                        RSP_ERR_O;
  logic                        CONTROL_VALID_O;
  logic                        CONTROL_READY_I = 1'b0;
  logic [TRB_CONTROL_BITS-1:0] CONTROL_O;
  logic                        STATUS_READY_O;
  logic                        STATUS_VALID_I = 1'b0;
  logic [TRB_STATUS_BITS-1:0]  STATUS_I = '0;
  logic                        DATA_VALID_O;
  logic                        DATA_READY_I = 1'b0;
  logic [TRB_WIDTH-1:0]        DATA_O;
  logic                        DATA_READY_O;
  logic                        DATA_VALID_I = 1'b0;
  logic [TRB_WIDTH-1:0]        DATA_I = '0;

  int checks = 0;
  int failures = 0;

  logic [TRB_WIDTH-1:0] words [4];

  stb_host_adapter #(
    .LEN_WIDTH  (LW),
    .TIMEOUT_CYC(16)
  ) dut (
    .CLK_I           (CLK_I),
    .RST_NI          (RST_NI),
    .CMD_VALID_I     (CMD_VALID_I),
    .CMD_READY_O     (CMD_READY_O),
    .CMD_OP_I        (CMD_OP_I),
    .CMD_LEN_I       (CMD_LEN_I),
    .CMD_DATA_I      (CMD_DATA_I),
    .RSP_VALID_O     (RSP_VALID_O),
    .RSP_READY_I     (RSP_READY_I),
    .RSP_DATA_O      (RSP_DATA_O),
    .RSP_LAST_O      (RSP_LAST_O),
    .RSP_ERR_O       (RSP_ERR_O),
    .CONTROL_VALID_O (CONTROL_VALID_O),
    .CONTROL_READY_I (CONTROL_READY_I),
    .CONTROL_O       (CONTROL_O),
    .STATUS_READY_O  (STATUS_READY_O),
    .STATUS_VALID_I  (STATUS_VALID_I),
    .STATUS_I        (STATUS_I),
    .DATA_VALID_O    (DATA_VALID_O),
    .DATA_READY_I    (DATA_READY_I),
    .DATA_O          (DATA_O),
    .DATA_READY_O    (DATA_READY_O),
    .DATA_VALID_I    (DATA_VALID_I),
    .DATA_I          (DATA_I)
  );

  always #5 CLK_I = ~CLK_I;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK_I);
    #1;
  endtask

  // Present one command for one accepting edge.
  task automatic issue(input string name, input logic [1:0] op, input logic [LW-1:0] len,
                       input logic [TRB_WIDTH-1:0] data);
    check({name, "_cmd_ready"}, CMD_READY_O, 1'b1);
    $display("txn %s op=%0d len=%0d data=0x%0h", name, op, len, data);
    CMD_VALID_I = 1'b1;
    CMD_OP_I    = op;
    CMD_LEN_I   = len;
    CMD_DATA_I  = data;
    tick();
    CMD_VALID_I = 1'b0;
    check({name, "_cmd_busy"}, CMD_READY_O, 1'b0);
  endtask

  // Accept a single final response beat within a bounded wait.
  task automatic take_beat(input string tag, input logic [TRB_WIDTH-1:0] exp_data,
                           input logic exp_err);
    int n;
    n = 0;
    RSP_READY_I = 1'b1;
    while (!RSP_VALID_O && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_rsp_valid"}, RSP_VALID_O, 1'b1);
    if (RSP_VALID_O) begin
      check({tag, "_rsp_data"}, RSP_DATA_O, exp_data);
      check({tag, "_rsp_last"}, RSP_LAST_O, 1'b1);
      check({tag, "_rsp_err"}, RSP_ERR_O, exp_err);
      $display("txn %s beat data=0x%0h last=%0d err=%0d", tag, RSP_DATA_O, RSP_LAST_O, RSP_ERR_O);
      tick();
    end
    RSP_READY_I = 1'b0;
    check({tag, "_rsp_drained"}, RSP_VALID_O, 1'b0);
    check({tag, "_ready_again"}, CMD_READY_O, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int widx, nb, cyc, overlap, seen;
    logic bhs;

    words[0] = 32'hA000_000A;
    words[1] = 32'hB000_000B;
    words[2] = 32'hC000_000C;
    words[3] = 32'hD000_000D;

    // Reset state
    RST_NI = 1'b0;
    tick();
    tick();
    check("rst_cmd_ready", CMD_READY_O, 1'b1);
    check("rst_rsp_valid", RSP_VALID_O, 1'b0);
    check("rst_ctrl_valid", CONTROL_VALID_O, 1'b0);
    check("rst_stat_ready", STATUS_READY_O, 1'b0);
    check("rst_data_valid", DATA_VALID_O, 1'b0);
    check("rst_data_ready", DATA_READY_O, 1'b0);
    check("rst_control", CONTROL_O, '0);
    check("rst_data_o", DATA_O, '0);
    RST_NI = 1'b1;
    tick();

    // 1: control write held through three stalled cycles
    issue("ctrl_wr", OP_CTRL_WR, '0, 32'hFFFF_FFF5);
    for (int i = 0; i < 4; i++) begin
      check("ctrl_valid_held", CONTROL_VALID_O, 1'b1);
      check("ctrl_word_stable", CONTROL_O, 4'h5);
      check("ctrl_no_early_rsp", RSP_VALID_O, 1'b0);
      if (i == 3) CONTROL_READY_I = 1'b1;
      tick();
    end
    CONTROL_READY_I = 1'b0;
    check("ctrl_valid_drop", CONTROL_VALID_O, 1'b0);
    check("ctrl_ack_now", RSP_VALID_O, 1'b1);
    take_beat("ctrl_ack", '0, 1'b0);

    // 2: status read, status arrives after two waiting cycles
    issue("stat_rd", OP_STAT_RD, '0, '0);
    for (int i = 0; i < 2; i++) begin
      check("stat_ready_held", STATUS_READY_O, 1'b1);
      tick();
    end
    STATUS_VALID_I = 1'b1;
    STATUS_I       = 8'h03;
    tick();
    STATUS_VALID_I = 1'b0;
    check("stat_ready_drop", STATUS_READY_O, 1'b0);
    take_beat("stat_rd", 32'h0000_0003, 1'b0);

    // Status with every bit set must not sign-extend
    STATUS_VALID_I = 1'b1;
    STATUS_I       = 8'hFF;
    issue("stat_ff", OP_STAT_RD, '0, '0);
    tick();
    STATUS_VALID_I = 1'b0;
    take_beat("stat_ff", 32'h0000_00FF, 1'b0);

    // Data word write
    issue("data_wr", OP_DATA_WR, '0, 32'hDEAD_BEEF);
    check("dwr_valid", DATA_VALID_O, 1'b1);
    check("dwr_word", DATA_O, 32'hDEAD_BEEF);
    tick();
    check("dwr_word_stable", DATA_O, 32'hDEAD_BEEF);
    DATA_READY_I = 1'b1;
    tick();
    DATA_READY_I = 1'b0;
    check("dwr_valid_drop", DATA_VALID_O, 1'b0);
    take_beat("data_wr", 32'h0000_0001, 1'b0);

    // 3: four-word burst with a toggling response consumer
    DATA_VALID_I = 1'b1;
    DATA_I       = words[0];
    RSP_READY_I  = 1'b0;
    issue("data_rd4", OP_DATA_RD, 8'd4, '0);
    widx = 0; nb = 0; cyc = 0; overlap = 0;
    while (nb < 4 && cyc < 100) begin
      if (DATA_READY_O && RSP_VALID_O) overlap++;
      if (RSP_VALID_O && RSP_READY_I) begin
        check("rd4_data", RSP_DATA_O, words[nb]);
        check("rd4_last", RSP_LAST_O, (nb == 3));
        check("rd4_err", RSP_ERR_O, 1'b0);
        $display("txn data_rd4 beat %0d data=0x%0h last=%0d", nb, RSP_DATA_O, RSP_LAST_O);
        nb++;
      end
      bhs = DATA_READY_O && DATA_VALID_I;
      tick();
      cyc++;
      if (bhs) widx++;
      DATA_VALID_I = (widx < 4);
      DATA_I       = words[(widx < 4) ? widx : 0];
      RSP_READY_I  = ~RSP_READY_I;
    end
    RSP_READY_I  = 1'b0;
    DATA_VALID_I = 1'b0;
    check("rd4_beats", nb, 4);
    check("rd4_words_taken", widx, 4);
    check("rd4_ready_vs_slot", overlap, 0);
    check("rd4_cmd_ready", CMD_READY_O, 1'b1);

    // 4: zero-length burst answers immediately without touching the buffer
    issue("data_rd0", OP_DATA_RD, 8'd0, '0);
    check("rd0_rsp_now", RSP_VALID_O, 1'b1);
    check("rd0_no_data_ready", DATA_READY_O, 1'b0);
    take_beat("data_rd0", '0, 1'b0);
    check("rd0_no_data_ready_after", DATA_READY_O, 1'b0);

    // 5: reset while the second word of a burst is waiting
    DATA_VALID_I = 1'b1;
    DATA_I       = words[0];
    issue("data_rd_rst", OP_DATA_RD, 8'd4, '0);
    check("rst5_data_ready", DATA_READY_O, 1'b1);
    tick();
    DATA_I = words[1];
    check("rst5_word1_held", RSP_VALID_O, 1'b1);
    check("rst5_slot_full_no_ready", DATA_READY_O, 1'b0);
    tick();
    RST_NI = 1'b0;
    tick();
    check("rst5_rsp_valid", RSP_VALID_O, 1'b0);
    check("rst5_cmd_ready", CMD_READY_O, 1'b1);
    check("rst5_data_ready", DATA_READY_O, 1'b0);
    check("rst5_ctrl_valid", CONTROL_VALID_O, 1'b0);
    check("rst5_stat_ready", STATUS_READY_O, 1'b0);
    check("rst5_data_valid", DATA_VALID_O, 1'b0);
    RST_NI       = 1'b1;
    DATA_VALID_I = 1'b0;
    RSP_READY_I  = 1'b1;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (RSP_VALID_O) seen++;
    end
    RSP_READY_I = 1'b0;
    check("rst5_no_partial_beat", seen, 0);

    // Adapter usable again after the reset
    STATUS_VALID_I = 1'b1;
    STATUS_I       = 8'h5A;
    issue("stat_post_rst", OP_STAT_RD, '0, '0);
    tick();
    STATUS_VALID_I = 1'b0;
    take_beat("stat_post_rst", 32'h0000_005A, 1'b0);

`ifdef STB_HOST_TIMEOUT_EN
    // 6: burst of three stalls after one word and is aborted
    DATA_VALID_I = 1'b1;
    DATA_I       = words[2];
    RSP_READY_I  = 1'b1;
    issue("data_rd_tmo", OP_DATA_RD, 8'd3, '0);
    tick();
    DATA_VALID_I = 1'b0;
    cyc = 0;
    while (!(RSP_VALID_O && RSP_ERR_O) && cyc < 40) begin
      tick();
      cyc++;
    end
    check("tmo_err_beat", RSP_VALID_O && RSP_ERR_O, 1'b1);
    check("tmo_latency_in_window", (cyc >= 16 && cyc <= 17), 1'b1);
    check("tmo_words_done", RSP_DATA_O, 32'h0000_0001);
    check("tmo_last", RSP_LAST_O, 1'b1);
    check("tmo_data_ready_dropped", DATA_READY_O, 1'b0);
    $display("txn data_rd_tmo abort after %0d cycles data=0x%0h", cyc, RSP_DATA_O);
    tick();
    RSP_READY_I = 1'b0;
    check("tmo_cmd_ready", CMD_READY_O, 1'b1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
